dds_sweep_ctrl: RTL
===================

# dds_sweep_ctrl

Frequency-sweep sequencer for the two-channel DDS test datapath. It accepts a sweep configuration over a valid/ready handshake and steps the phase-increment words feeding the channel A and channel B DDS cores. Each word is held for a programmable dwell, with single, repeat and triangle modes. It sits between the host/config logic and the DDS cores in `dds_test_top`, and freezes while the downstream sample FIFO asserts hold.

## Interface
- `PHASE_WIDTH`, 32, phase-increment (tuning word) width
- `COUNT_WIDTH`, 12, width of the step count
- `DWELL_WIDTH`, 16, width of the dwell-cycle count
- `clk_in`  in  1  system clock
- `rst_in`  in  1  reset; asynchronous, active-low
- `cfg_valid_in`  in  1  configuration valid
- `cfg_ready_out`  out  1  configuration accepted when high with valid
- `cfg_start_in`  in  PHASE_WIDTH  first tuning word
- `cfg_step_in`  in  PHASE_WIDTH  unsigned step added per point
- `cfg_count_in`  in  COUNT_WIDTH  number of points N (0 treated as 1)
- `cfg_dwell_in`  in  DWELL_WIDTH  cycles per point (0 treated as 1)
- `cfg_offset_in`  in  PHASE_WIDTH  channel B offset from channel A
- `cfg_mode_in`  in  2  0 single, 1 repeat, 2 triangle, 3 reserved (behaves as single)
- `run_in`  in  1  start the sweep (level-sampled in IDLE)
- `abort_in`  in  1  stop immediately
- `hold_in`  in  1  freeze dwell counting (sample FIFO full)
- `pincA_out`  out  PHASE_WIDTH  channel A tuning word
- `pincB_out`  out  PHASE_WIDTH  channel B tuning word, = pincA + offset mod 2^PHASE_WIDTH
- `pinc_valid_out`  out  1  one-cycle pulse when the tuning words change
- `busy_out`  out  1  high outside IDLE
- `done_out`  out  1  one-cycle pulse at normal sweep completion

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `cfg_ready_out`=1 in IDLE only. A handshake latches all `cfg_*` fields.
  - `run_in`=1 with a config loaded moves to RUN. Without a loaded config, `run_in` is ignored.
  - A config stays loaded after a sweep, so a re-run needs no reload.
- **RUN entry**
  - Tuning word = start, point index = 0, direction = up.
  - Dwell counter loads max(dwell,1)-1.
- **RUN, each cycle**
  - If `hold_in`=1, nothing changes.
  - Otherwise the dwell counter decrements.
  - When it reaches 0, the point ends and the next action follows the mode.
- **single**
  - Index < N-1: word += step, index++.
  - Otherwise go to DONE.
- **repeat**
  - Index < N-1: step as in single.
  - Otherwise word = start, index = 0.
- **triangle**
  - Up and index < N-1: add step, index++.
  - At index N-1, direction flips to down, then subtract step, index--.
  - At index 0 while down, direction flips to up, then add step.
  - Endpoints are not repeated. N=1 holds start.
  - Never completes; only abort ends it.
- All arithmetic is modulo 2^PHASE_WIDTH. Wrap-around is legal and silent.
- **DONE**: `done_out`=1 for one cycle, then IDLE. Tuning words hold their last value.
- **abort_in** in any state:
  - Next state is IDLE.
  - Both tuning words go to 0, with a `pinc_valid_out` pulse.
  - No `done_out`.
  - abort has priority over run, hold and dwell expiry.

## Timing
- Reset values:
  - All outputs 0, except `cfg_ready_out`=1.
  - State IDLE, no config loaded.
- Every new tuning word is registered. `pincA_out`, `pincB_out` and `pinc_valid_out` update in the same cycle.
- `run_in` sampled at edge t: `busy_out`=1, start word and `pinc_valid_out` are visible after edge t.
- A point with dwell D (no hold) is present for exactly D cycles. Hold cycles extend it one for one.
- `pinc_valid_out` pulses once per point change. In repeat with N=1 it pulses each dwell expiry (reload of start).
- Single mode, last point: DONE is entered after D cycles. `done_out` is high the next cycle, then `busy_out`=0 the cycle after.
- A config handshake in the same cycle as `run_in`: the new config is latched, and the sweep starts one cycle later using it.
- Reset mid-sweep: asynchronous return to reset values. No pulse is generated.

## Structure
- Shared package `dds_pkg`:
  - mode encodings (`MODE_SINGLE`/`MODE_REPEAT`/`MODE_TRIANGLE`)
  - state enumeration
  - default `PHASE_WIDTH`
- Sub-module `dds_dwell_timer`: loadable down-counter with hold and an expiry pulse.
- The sequencing FSM and the offset adder stay in the top module.

## Test plan
- **single**: start=1000, step=250, N=4, dwell=3, offset=0 -> A = 1000, 1250, 1500, 1750, each for 3 cycles. 4 valid pulses, then `done_out` once, then `busy_out` low.
- **triangle**: start=0, step=10, N=3, dwell=1 -> A sequence 0, 10, 20, 10, 0, 10, 20… with no repeated endpoints. `done_out` is never asserted.
- **wrap + channel B**: start=0xFFFFFFF0, step=0x20, offset=0x100, N=2 -> A = 0xFFFFFFF0 then 0x10; B = 0xF0 then 0x110.
- **hold**: dwell=4 with `hold_in` high for 5 cycles mid-point -> that point lasts 9 cycles. The other points last 4.
- **abort**: abort in repeat mode at point 2 -> A=B=0 and `pinc_valid_out` pulse the next cycle, IDLE, no `done_out`. A re-run without reconfiguring restarts at start.
- **reset and zero edge cases**:
  - Assert `rst_in` low mid-dwell -> all outputs 0, `cfg_ready_out`=1.
  - N=0, dwell=0 -> one point of one cycle, then done.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep sequencer.
//   DEFAULT_PHASE_WIDTH : default tuning-word width
//   MODE_*              : sweep mode encodings (3 is reserved and runs as single)
//   state_e             : sequencer state enumeration
package dds_pkg;

    localparam int unsigned DEFAULT_PHASE_WIDTH = 32;

    localparam logic [1:0] MODE_SINGLE   = 2'd0;
    localparam logic [1:0] MODE_REPEAT   = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter measuring how long each sweep point is held.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_val_i (wins over counting)
//   load_val_i    : cycles-minus-one for the next point
//   enable_i      : count this cycle (low while frozen or not sweeping)
//   expire_o      : combinational pulse in the cycle the count is 0 and enabled
module dds_dwell_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             enable_i,
    output logic             expire_o
);

    logic [Width-1:0] count_q;

    assign expire_o = enable_i && (count_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (enable_i && (count_q != '0)) begin
            count_q <= count_q - Width'(1);
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the two-channel DDS datapath.
// Steps the channel A tuning word through a configured sweep (single, repeat or
// triangle), holding each point for a programmable dwell; channel B tracks A plus
// a fixed offset. Dwell counting freezes while hold_in is high.
//   cfg_*          : configuration, latched on cfg_valid_in && cfg_ready_out (IDLE only)
//   run_in         : start request, level-sampled in IDLE with a config loaded
//   abort_in       : return to IDLE, zero both tuning words (highest priority)
//   hold_in        : freeze the current point
//   pincA_out/B    : registered tuning words, pinc_valid_out pulses on every change
//   busy_out       : high outside IDLE; done_out pulses once at sweep completion
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
    parameter int unsigned COUNT_WIDTH = 12,
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   cfg_valid_in,
    output logic                   cfg_ready_out,
    input  logic [PHASE_WIDTH-1:0] cfg_start_in,
    input  logic [PHASE_WIDTH-1:0] cfg_step_in,
    input  logic [COUNT_WIDTH-1:0] cfg_count_in,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell_in,
    input  logic [PHASE_WIDTH-1:0] cfg_offset_in,
    input  logic [1:0]             cfg_mode_in,
    input  logic                   run_in,
    input  logic                   abort_in,
    input  logic                   hold_in,
    output logic [PHASE_WIDTH-1:0] pincA_out,
    output logic [PHASE_WIDTH-1:0] pincB_out,
    output logic                   pinc_valid_out,
    output logic                   busy_out,
    output logic                   done_out
);

    state_e                 state_q;
    logic [PHASE_WIDTH-1:0] start_q, step_q, offset_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [1:0]             mode_q;
    logic                   loaded_q;
    logic                   start_pend_q;  // config and run arrived together
    logic [PHASE_WIDTH-1:0] word_q, word_b_q;
    logic [COUNT_WIDTH-1:0] idx_q;
    logic                   down_q;
    logic                   pinc_valid_q, busy_q, done_q, cfg_ready_q;

    logic                   cfg_fire;
    logic                   start_sweep;
    logic                   expire;
    logic                   timer_load;
    logic [COUNT_WIDTH-1:0] last_idx;
    logic [DWELL_WIDTH-1:0] dwell_load;
    logic                   at_last;
    logic [PHASE_WIDTH-1:0] nxt_word;
    logic [COUNT_WIDTH-1:0] nxt_idx;
    logic                   nxt_down;
    logic                   nxt_change;
    logic                   nxt_finish;

    assign cfg_fire    = cfg_valid_in && cfg_ready_q;
    // A same-cycle config handshake defers the start by one cycle.
    assign start_sweep = (state_q == StIdle) && !abort_in && !cfg_fire &&
                         (start_pend_q || (run_in && loaded_q));

    // Next point once the current dwell expires.
    always_comb begin
        last_idx   = (count_q == '0) ? '0 : count_q - COUNT_WIDTH'(1);
        dwell_load = (dwell_q == '0) ? '0 : dwell_q - DWELL_WIDTH'(1);
        at_last    = (idx_q == last_idx);
        nxt_word   = word_q;
        nxt_idx    = idx_q;
        nxt_down   = down_q;
        nxt_change = 1'b0;
        nxt_finish = 1'b0;
        case (mode_q)
            MODE_REPEAT: begin
                nxt_change = 1'b1;
                if (!at_last) begin
                    nxt_word = word_q + step_q;
                    nxt_idx  = idx_q + COUNT_WIDTH'(1);
                end else begin
                    nxt_word = start_q;
                    nxt_idx  = '0;
                end
            end
            MODE_TRIANGLE: begin
                // A single-point triangle just sits on start.
                if (last_idx != '0) begin
                    nxt_change = 1'b1;
                    if (!down_q && !at_last) begin
                        nxt_word = word_q + step_q;
                        nxt_idx  = idx_q + COUNT_WIDTH'(1);
                    end else if (!down_q) begin
                        nxt_down = 1'b1;
                        nxt_word = word_q - step_q;
                        nxt_idx  = idx_q - COUNT_WIDTH'(1);
                    end else if (idx_q != '0) begin
                        nxt_word = word_q - step_q;
                        nxt_idx  = idx_q - COUNT_WIDTH'(1);
                    end else begin
                        nxt_down = 1'b0;
                        nxt_word = word_q + step_q;
                        nxt_idx  = idx_q + COUNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                if (!at_last) begin
                    nxt_change = 1'b1;
                    nxt_word   = word_q + step_q;
                    nxt_idx    = idx_q + COUNT_WIDTH'(1);
                end else begin
                    nxt_finish = 1'b1;
                end
            end
        endcase
    end

    assign timer_load = start_sweep ||
                        ((state_q == StRun) && !abort_in && expire && !nxt_finish);

    dds_dwell_timer #(
        .Width (DWELL_WIDTH)
    ) u_dwell_timer (
        .clk_i      (clk_in),
        .rst_ni     (rst_in),
        .load_i     (timer_load),
        .load_val_i (dwell_load),
        .enable_i   ((state_q == StRun) && !hold_in),
        .expire_o   (expire)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= StIdle;
            start_q      <= '0;
            step_q       <= '0;
            offset_q     <= '0;
            count_q      <= '0;
            dwell_q      <= '0;
            mode_q       <= MODE_SINGLE;
            loaded_q     <= 1'b0;
            start_pend_q <= 1'b0;
            word_q       <= '0;
            word_b_q     <= '0;
            idx_q        <= '0;
            down_q       <= 1'b0;
            pinc_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_ready_q  <= 1'b1;
        end else begin
            pinc_valid_q <= 1'b0;
            done_q       <= 1'b0;

            // cfg_ready_q is only high in IDLE, so a handshake is always honoured.
            if (cfg_fire) begin
                start_q  <= cfg_start_in;
                step_q   <= cfg_step_in;
                count_q  <= cfg_count_in;
                dwell_q  <= cfg_dwell_in;
                offset_q <= cfg_offset_in;
                mode_q   <= cfg_mode_in;
                loaded_q <= 1'b1;
            end

            if (abort_in) begin
                state_q      <= StIdle;
                word_q       <= '0;
                word_b_q     <= '0;
                pinc_valid_q <= 1'b1;
                busy_q       <= 1'b0;
                start_pend_q <= 1'b0;
                cfg_ready_q  <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cfg_fire) begin
                            start_pend_q <= run_in;
                            cfg_ready_q  <= !run_in;
                        end else if (start_sweep) begin
                            state_q      <= StRun;
                            word_q       <= start_q;
                            word_b_q     <= start_q + offset_q;
                            pinc_valid_q <= 1'b1;
                            idx_q        <= '0;
                            down_q       <= 1'b0;
                            busy_q       <= 1'b1;
                            start_pend_q <= 1'b0;
                            cfg_ready_q  <= 1'b0;
                        end
                    end
                    StRun: begin
                        if (expire) begin
                            if (nxt_finish) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                idx_q  <= nxt_idx;
                                down_q <= nxt_down;
                                if (nxt_change) begin
                                    word_q       <= nxt_word;
                                    word_b_q     <= nxt_word + offset_q;
                                    pinc_valid_q <= 1'b1;
                                end
                            end
                        end
                    end
                    StDone: begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                    end
                    default: begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign cfg_ready_out  = cfg_ready_q;
    assign pincA_out      = word_q;
    assign pincB_out      = word_b_q;
    assign pinc_valid_out = pinc_valid_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;

endmodule
